// File: rtl/nibble_pkg.sv
// Shared types and helpers for the nibble packer and its output register slice.

package nibble_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef logic [NIBBLE_W-1:0] nibble_t;

   // FILL collects nibbles; HOLD keeps a completed word while the output slot is busy.
   typedef enum logic {
      StFill,
      StHold
   } pack_state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/nibble_out_reg.sv
// One-entry valid/ready register slice. Data is held stable while valid && !ready.

module nibble_out_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   output logic         free,
   output logic         valid,
   output logic [W-1:0] data,
   input  logic         ready
);

   // Free when empty or draining this cycle, so a reload causes no bubble.
   assign free = !valid || ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load && free) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/nibble_packer.sv
// Packs a valid/ready nibble stream LSB-first into NIBBLES-wide words; in_last flushes early.

module nibble_packer
   import nibble_pkg::*;
#(
   parameter int unsigned  NIBBLES = 4,
   localparam int unsigned OUT_W   = NIBBLE_W * NIBBLES,
   localparam int unsigned CNT_W   = cnt_w(NIBBLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  nibble_t          in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_valid,
   input  logic             out_ready
);

   pack_state_t      state;
   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] acc_wr;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] count;
   logic             accept;
   logic             complete;
   logic             load;
   logic             out_free;
   logic [CNT_W+OUT_W-1:0] out_word;

   assign in_ready = (state == StFill);

   always_comb begin
      accept   = in_valid && (state == StFill);
      complete = accept && (in_last || (idx == CNT_W'(NIBBLES - 1)));
      load     = (complete || (state == StHold)) && out_free;
      // In HOLD idx still points at the last written slot.
      count    = idx + CNT_W'(1);
      acc_wr   = acc;
      for (int k = 0; k < int'(NIBBLES); k++) begin
         if (accept && (idx == CNT_W'(k))) begin
            acc_wr[NIBBLE_W*k +: NIBBLE_W] = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= StFill;
         acc   <= '0;
         idx   <= '0;
      end else if (load) begin
         state <= StFill;
         acc   <= '0;
         idx   <= '0;
      end else if (complete) begin
         state <= StHold;
         acc   <= acc_wr;
      end else if (accept) begin
         acc   <= acc_wr;
         idx   <= idx + CNT_W'(1);
      end
   end

   nibble_out_reg #(
      .W(CNT_W + OUT_W)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data ({count, acc_wr}),
      .free      (out_free),
      .valid     (out_valid),
      .data      (out_word),
      .ready     (out_ready)
   );

   assign out_count = out_word[CNT_W+OUT_W-1:OUT_W];
   assign out_data  = out_word[OUT_W-1:0];

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Packs the 4-bit nibble stream produced by `submod` (`data[3:0]`) into wide words for downstream consumers, and sits directly after it in `test_autowire`. Nibbles enter on a valid/ready handshake and are assembled LSB-first into an accumulator. Completed words go through a one-entry output register with its own valid/ready handshake. `in_last` flushes a partial word early and reports how many nibbles it holds.

## Interface
- `NIBBLES`, default 4: nibbles per output word. Legal range 2..16.
- `OUT_W`: localparam, `4*NIBBLES`.
- `CNT_W`: localparam, `$clog2(NIBBLES+1)`.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_data`, input, 4: nibble from the upstream stage.
- `in_valid`, input, 1: `in_data` is valid.
- `in_last`, input, 1: this nibble closes the current word. Sampled only on an accepted handshake.
- `in_ready`, output, 1: the block accepts a nibble this cycle.
- `out_data`, output, OUT_W: packed word. Nibble k sits at bits [4k+3:4k].
- `out_count`, output, CNT_W: number of valid nibbles in `out_data` (1..NIBBLES).
- `out_valid`, output, 1: `out_data` and `out_count` are valid.
- `out_ready`, input, 1: the consumer accepts the word.

## Operation
- Transfer rules:
  - Input transfer when `in_valid && in_ready`.
  - Output transfer when `out_valid && out_ready`.
- Accumulator state: `acc` (OUT_W bits), `idx` (CNT_W bits), and a `acc_full` flag.
- States:
  - FILL (`acc_full`=0): each accepted nibble is written at slot `idx`, then `idx` increments.
  - HOLD (`acc_full`=1): the word is complete but could not be moved out yet.
- FILL → completion happens when the accepted nibble has `idx==NIBBLES-1` or `in_last=1`. Then:
  - If the output register is empty, or is draining in the same cycle, the word moves to the output register. `out_count`=`idx+1`. `acc` and `idx` clear, and the block stays in FILL.
  - Otherwise the block enters HOLD.
- HOLD → FILL: on the cycle the output register is empty or draining, the held word moves to the output register. `acc` and `idx` clear.
- `in_ready` = !`acc_full`. It is registered-state-based and has no combinational path from `in_valid`.
- Slot clearing: unused upper slots of a flushed partial word are 0. The accumulator is cleared on every transfer out, so stale nibbles never leak.
- `in_last` on the NIBBLES-th nibble is identical to a normal full word (`out_count`=NIBBLES).
- Output register stability: holds `out_data`/`out_count` stable while `out_valid && !out_ready`.
- Same-cycle drain and reload: when a new word is loaded in the same cycle the old one drains, `out_valid` stays 1 with no bubble.
- Mid-operation reset: `rst_n` low at any time discards any partial or held word. No output is produced for it.

## Timing
- Reset values, asynchronous on `rst_n`=0:
  - `out_valid`=0, `out_data`=0, `out_count`=0.
  - `in_ready`=1.
  - `acc`=0, `idx`=0, `acc_full`=0.
- Latency: a word appears at the outputs (`out_valid`=1) on the cycle after its completing input handshake, provided the output register is free.
- Throughput: 1 nibble/cycle sustained when `out_ready`=1 continuously. Words are emitted every NIBBLES cycles with no stall.
- Backpressure: with `out_ready`=0, the block accepts at most 2 words (output register plus a full accumulator). `in_ready` then drops on the cycle after the second word completes.
- Recovery after backpressure: `in_ready` returns to 1 on the cycle after the output handshake that frees the path.

## Structure
- Shared package `nibble_pkg`:
  - `NIBBLE_W`=4.
  - Typedef `nibble_t` (logic [3:0]).
  - Function `cnt_w(n)` = `$clog2(n+1)`.
- One sub-module, `nibble_out_reg`: a one-entry valid/ready register slice carrying `{out_count, out_data}`, parameterized by width. The accumulator FSM stays in `nibble_packer`.

## Test plan
- Reset, then 8 nibbles 1..8 with `out_ready`=1 (NIBBLES=4) → words 0x4321 and 0x8765, each with `out_count`=4, one cycle after the 4th/8th accepted nibble. `in_ready` stays 1 throughout.
- Nibbles A, B with `in_last` on B → `out_data`=0x00BA, `out_count`=2. The next word starts at slot 0.
- `out_ready`=0 while streaming 12 nibbles:
  - Words 1 and 2 are absorbed, and `in_ready` falls after nibble 8.
  - `out_data` stays stable (0x4321).
  - Raising `out_ready` drains 0x4321 then 0x8765, then input resumes.
- Back-to-back full words with `out_ready` toggling every cycle → no word lost or duplicated, and the `out_count`/`out_data` sequence matches the input order.
- Assert `rst_n`=0 after 2 nibbles of a word, release, send 4 nibbles 5,6,7,8 → single output 0x8765. No partial word emitted.
- `in_last` on the 4th nibble → identical to the full-word case (`out_count`=4). `in_last` with `in_valid`=0 → ignored.
